// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the MIPS core front end.
//   XLEN             : datapath / instruction width
//   WORD_ADDR_W      : width of a word address (PC[31:2])
//   RESET_PC_DEFAULT : first fetch address after reset
//   ifu_state_e      : fetch-unit request tracking states
//   ifu_entry_t      : one prefetch buffer entry {pc, inst}
//   align_pc()       : clears the byte-offset bits of a PC
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int XLEN        = 32;
  localparam int WORD_ADDR_W = 30;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // IDLE: nothing outstanding; WAIT: outstanding, keep data;
  // DISCARD: outstanding, data belongs to a squashed path.
  typedef enum logic [1:0] {
    IFU_IDLE    = 2'd0,
    IFU_WAIT    = 2'd1,
    IFU_DISCARD = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } ifu_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// -----------------------------------------------------------------------------
// ifu_prefetch_if
// Bundles the fetch unit's bus-level signals.
//   imem_req/imem_addr          : fetch request pulse and word address
//   imem_rvalid/imem_rdata      : instruction memory response
//   redirect_valid/redirect_pc  : branch/jump resolution restart
//   inst_valid/inst_ready       : decode handshake
//   inst_data/inst_pc           : instruction and its PC at the buffer head
// Modports:
//   master : the fetch unit (drives requests and the decode side)
//   slave  : its environment (memory, branch unit and decode)
// -----------------------------------------------------------------------------
interface ifu_prefetch_if;
  import mips_pkg::*;

  logic                   imem_req;
  logic [WORD_ADDR_W-1:0] imem_addr;
  logic                   imem_rvalid;
  logic [XLEN-1:0]        imem_rdata;
  logic                   redirect_valid;
  logic [XLEN-1:0]        redirect_pc;
  logic                   inst_valid;
  logic                   inst_ready;
  logic [XLEN-1:0]        inst_data;
  logic [XLEN-1:0]        inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/ifu_fifo.sv
// -----------------------------------------------------------------------------
// ifu_fifo
// Synchronous prefetch buffer of DEPTH {pc, inst} entries.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_entry at the tail (caller guarantees not full)
//   pop         : drop the head entry (caller guarantees not empty)
//   clear       : empty the buffer; overrides push and pop
//   push_entry  : entry written on push
//   count       : current number of entries
//   head_valid  : buffer not empty
//   head_entry  : head entry; while empty it repeats the last value shown
// Parameters:
//   DEPTH       : number of entries, power of two, >= 2
// -----------------------------------------------------------------------------
module ifu_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  ifu_entry_t       push_entry,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output ifu_entry_t       head_entry
);

  ifu_entry_t       mem_q [DEPTH];
  ifu_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  ifu_entry_t       hold_q, hold_d;

  assign count      = count_q;
  assign head_valid = (count_q != '0);

  // hold_q remembers what was presented last cycle so the decode-facing
  // outputs stay stable once the buffer drains or is flushed.
  assign head_entry = head_valid ? mem_q[rd_ptr_q] : hold_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    hold_d   = head_entry;

    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// -----------------------------------------------------------------------------
// ifu_prefetch
// Instruction-fetch front end sitting directly upstream of decode. Issues
// word fetches (at most one outstanding), buffers returned words with their
// PCs, and hands them to decode over a valid/ready handshake. A redirect
// flushes the buffer and squashes any in-flight fetch.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ifu_prefetch_if.master (memory request/response, redirect,
//              decode handshake)
//   perf_fetch_cnt (32), perf_flush_cnt (16), perf_stall_cnt (32):
//              saturating event counters, present only when the macro
//              IFU_PREFETCH_PERF_EN is defined
// Parameters:
//   DEPTH    : prefetch buffer entries, power of two, >= 2
//   RESET_PC : first fetch address after reset
// -----------------------------------------------------------------------------
module ifu_prefetch
  import mips_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  ifu_prefetch_if.master        bus
`ifdef IFU_PREFETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [15:0]           perf_flush_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic             push;
  logic             pop;
  logic             issue;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   count_after_push;
  logic             head_valid;
  ifu_entry_t       head_entry;
  ifu_entry_t       push_entry;

  // A redirect suppresses every same-cycle buffer update and request.
  // Space is judged before any same-cycle pop, so a full buffer only
  // restarts fetching the cycle after its count has actually dropped.
  assign push             = bus.imem_rvalid && (state_q == IFU_WAIT) && !bus.redirect_valid;
  assign pop              = head_valid && bus.inst_ready && !bus.redirect_valid;
  assign count_after_push = {1'b0, fifo_count} + (CNT_W+1)'(push);
  assign issue            = !bus.redirect_valid
                            && ((state_q == IFU_IDLE) || bus.imem_rvalid)
                            && (count_after_push < (CNT_W+1)'(DEPTH));

  assign bus.imem_req   = issue && !rst;
  assign bus.imem_addr  = fetch_pc_q[XLEN-1:2];
  assign bus.inst_valid = head_valid;
  assign bus.inst_pc    = head_entry.pc;
  assign bus.inst_data  = head_entry.inst;

  assign push_entry.pc   = req_pc_q;
  assign push_entry.inst = bus.imem_rdata;

  ifu_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .clear      (bus.redirect_valid),
    .push_entry (push_entry),
    .count      (fifo_count),
    .head_valid (head_valid),
    .head_entry (head_entry)
  );

  // A request outstanding at redirect time whose response has not arrived
  // yet must still be drained, so it moves to DISCARD rather than IDLE.
  // A response in IDLE is a leftover from before reset and is ignored.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;

    if (bus.redirect_valid) begin
      fetch_pc_d = align_pc(bus.redirect_pc);
      if ((state_q != IFU_IDLE) && !bus.imem_rvalid) begin
        state_d = IFU_DISCARD;
      end else begin
        state_d = IFU_IDLE;
      end
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        req_pc_d   = fetch_pc_q;
      end
      unique case (state_q)
        IFU_IDLE: begin
          if (issue) begin
            state_d = IFU_WAIT;
          end
        end
        IFU_WAIT, IFU_DISCARD: begin
          if (bus.imem_rvalid) begin
            state_d = issue ? IFU_WAIT : IFU_IDLE;
          end
        end
        default: state_d = IFU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IFU_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [15:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_stall_cnt = perf_stall_q;

  // All counters stick at their maximum instead of wrapping.
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_flush_d = perf_flush_q;
    perf_stall_d = perf_stall_q;
    if (push && (perf_fetch_q != '1)) begin
      perf_fetch_d = perf_fetch_q + 32'd1;
    end
    if (bus.redirect_valid && (perf_flush_q != '1)) begin
      perf_flush_d = perf_flush_q + 16'd1;
    end
    if (bus.inst_ready && !head_valid && !bus.redirect_valid && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
      perf_stall_q <= perf_stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// -----------------------------------------------------------------------------
// tb_ifu_prefetch
// Drives ifu_prefetch with a latency-programmable instruction memory model,
// redirects and decode back-pressure. Expected {pc, inst} pairs are queued
// when the memory returns a word that should be kept and compared as decode
// accepts them; fetch addresses are tracked by an independent PC model.
// Perf counter checks are compiled in when IFU_PREFETCH_PERF_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ifu_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ifu_prefetch_if bus ();

`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] perfFetchCnt;
  logic [15:0] perfFlushCnt;
  logic [31:0] perfStallCnt;
`endif

  ifu_prefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IFU_PREFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perfFetchCnt),
    .perf_flush_cnt (perfFlushCnt),
    .perf_stall_cnt (perfStallCnt)
`endif
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int failCount  = 0;

  // Stimulus knobs
  int          latency;
  bit          readyIn;
  bit          redirReq;
  logic [31:0] redirPc;
  bit          junkRvalid;

  // Memory model: one outstanding request
  bit          pendValid;
  bit          pendKeep;
  int          pendCnt;
  logic [31:0] pendPc;

  // Scoreboard and reference models
  logic [63:0] expQ[$];
  logic [31:0] expFetchPc;
  logic [31:0] popPcs[$];
  int          reqCount;
  int          popCount;
  int          pushCount;
  int          stallCount;
  int          cycleIdx;
  int          firstValidIdx;
  bit          lastReq;
  logic [29:0] firstReqAddr;

  function automatic logic [31:0] memWord(input logic [31:0] pc);
    return pc ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] popPcAt(input int idx);
    if (popPcs.size() > idx) return popPcs[idx];
    return 32'hDEAD_DEAD;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearReqLog();
    reqCount     = 0;
    firstReqAddr = '1;
  endtask

  // One clock cycle: entered just after a rising edge, leaves just after
  // the next one. Inputs are driven first, outputs sampled mid-cycle.
  task automatic applyStimulus();
    bit          respNow;
    bit          busy;
    logic [63:0] expEntry;

    respNow = 1'b0;
    if (pendValid) begin
      pendCnt--;
      if (pendCnt == 0) respNow = 1'b1;
    end
    bus.imem_rvalid    = respNow || junkRvalid;
    bus.imem_rdata     = respNow ? memWord(pendPc) : (junkRvalid ? 32'hBAD0_BAD0 : 32'h0);
    junkRvalid         = 1'b0;
    bus.redirect_valid = redirReq;
    bus.redirect_pc    = redirPc;
    bus.inst_ready     = readyIn;

    #3;

    checkOutput("instValid", bus.inst_valid, expQ.size() != 0);
    if (bus.inst_valid && (firstValidIdx < 0)) firstValidIdx = cycleIdx;
    if (readyIn && !redirReq && (expQ.size() == 0)) stallCount++;
    if (bus.inst_valid && readyIn && !redirReq && (expQ.size() != 0)) begin
      expEntry = expQ.pop_front();
      checkOutput("instHead", {bus.inst_pc, bus.inst_data}, expEntry);
      popPcs.push_back(bus.inst_pc);
      popCount++;
    end

    lastReq = bus.imem_req;
    busy    = redirReq || (pendValid && !respNow);
    if (bus.imem_req) begin
      checkOutput("reqLegal", busy, 1'b0);
      checkOutput("imemAddr", bus.imem_addr, expFetchPc[31:2]);
      if (reqCount == 0) firstReqAddr = bus.imem_addr;
      reqCount++;
    end

    if (respNow) begin
      pendValid = 1'b0;
      if (pendKeep && !redirReq) begin
        expQ.push_back({pendPc, memWord(pendPc)});
        pushCount++;
      end
    end

    if (redirReq) begin
      expQ.delete();
      if (pendValid) pendKeep = 1'b0;
      expFetchPc = {redirPc[31:2], 2'b00};
    end else if (bus.imem_req) begin
      pendValid  = 1'b1;
      pendKeep   = 1'b1;
      pendCnt    = latency;
      pendPc     = expFetchPc;
      expFetchPc = expFetchPc + 32'd4;
    end

    redirReq = 1'b0;
    cycleIdx++;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset (possibly mid-cycle), checks the asynchronous response,
  // and releases it just after a rising edge so the next cycle is cycle 0.
  task automatic resetDut();
    rst                = 1'b1;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.inst_ready     = 1'b0;
    readyIn       = 1'b0;
    redirReq      = 1'b0;
    redirPc       = 32'h0;
    junkRvalid    = 1'b0;
    pendValid     = 1'b0;
    pendKeep      = 1'b0;
    pendCnt       = 0;
    expQ.delete();
    popPcs.delete();
    expFetchPc    = RESET_PC;
    popCount      = 0;
    pushCount     = 0;
    stallCount    = 0;
    firstValidIdx = -1;
    clearReqLog();
    #1;
    checkOutput("rstImemReq", bus.imem_req, 1'b0);
    checkOutput("rstInstValid", bus.inst_valid, 1'b0);
    checkOutput("rstInstData", bus.inst_data, 32'h0);
    checkOutput("rstInstPc", bus.inst_pc, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    cycleIdx = 0;
  endtask

  initial begin
    #2;

    // 1: streaming at one instruction per cycle
    resetDut();
    latency = 1;
    readyIn = 1'b1;
    repeat (20) applyStimulus();
    checkOutput("t1FirstValidCycle", firstValidIdx, 2);
    checkOutput("t1PopCount", popCount, 18);

    // 2: decode stalled, buffer fills then fetch resumes
    resetDut();
    latency = 1;
    readyIn = 1'b0;
    repeat (10) applyStimulus();
    checkOutput("t2ReqCount", reqCount, DEPTH);
    checkOutput("t2HeadValid", bus.inst_valid, 1'b1);
    checkOutput("t2HeadPc", bus.inst_pc, 32'h0000_3000);
    readyIn = 1'b1;
    clearReqLog();
    repeat (8) applyStimulus();
    checkOutput("t2ResumeAddr", firstReqAddr, 30'h0000_0C04);

    // 3: redirect with a slow fetch in flight
    resetDut();
    latency = 3;
    readyIn = 1'b1;
    applyStimulus();
    redirReq = 1'b1;
    redirPc  = 32'h0000_4000;
    applyStimulus();
    clearReqLog();
    popPcs.delete();
    repeat (12) applyStimulus();
    checkOutput("t3ReqAddr", firstReqAddr, 30'h0000_1000);
    checkOutput("t3FirstPc", popPcAt(0), 32'h0000_4000);

    // 4: redirect coinciding with a response and a ready decode
    resetDut();
    latency = 1;
    readyIn = 1'b1;
    repeat (6) applyStimulus();
    redirReq = 1'b1;
    redirPc  = 32'h0000_4002;
    applyStimulus();
    clearReqLog();
    popPcs.delete();
    applyStimulus();
    checkOutput("t4ReqNextCycle", lastReq, 1'b1);
    checkOutput("t4ReqAddr", firstReqAddr, 30'h0000_1000);
    repeat (4) applyStimulus();
    checkOutput("t4FirstPc", popPcAt(0), 32'h0000_4000);

    // 5: reset while a fetch is outstanding, stale response afterwards
    resetDut();
    latency = 1;
    readyIn = 1'b1;
    repeat (5) applyStimulus();
    latency = 3;
    repeat (2) applyStimulus();
    resetDut();
    latency    = 1;
    readyIn    = 1'b1;
    junkRvalid = 1'b1;
    repeat (6) applyStimulus();
    checkOutput("t5FirstPc", popPcAt(0), 32'h0000_3000);

    // 6: PC wrap at the top of the address space
    resetDut();
    latency = 1;
    readyIn = 1'b1;
    repeat (3) applyStimulus();
    redirReq = 1'b1;
    redirPc  = 32'hFFFF_FFFC;
    applyStimulus();
    popPcs.delete();
    repeat (6) applyStimulus();
    checkOutput("t6WrapPc0", popPcAt(0), 32'hFFFF_FFFC);
    checkOutput("t6WrapPc1", popPcAt(1), 32'h0000_0000);
`ifdef IFU_PREFETCH_PERF_EN
    checkOutput("t6PerfFlush", perfFlushCnt, 16'd1);
    checkOutput("t6PerfFetch", perfFetchCnt, pushCount);
    checkOutput("t6PerfStall", perfStallCnt, stallCount);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
